// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared types and constants for the FP8 systolic array front
//                end: FP8 lane width, the zero byte injected as a bubble, the
//                feeder state encoding and the drain-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int               FP8_W    = 8;
    localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Cycles for the last injected value to cross the whole N x N grid.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : DEPTH-stage register pipeline used to skew one operand lane
//                onto the edge of the systolic grid. Asynchronous active-low
//                reset clears every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift the lane value one stage per clock; reset flushes the whole line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule : skew_delay_line
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : Operand feeder for the N x N FP8 E4M3 PE grid. Accepts one
//                K-step beat (A column, B row) per handshake, skews lane i by
//                i cycles onto the west/north grid edges, pulses pe_clear
//                before the first operand, fills bubbles and the drain with
//                zero bytes and pulses done once every accumulator is final.
//                Optional build macro FEEDER_STALL_CNT_EN adds stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import tpu_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*FP8_W-1:0] a_vec,
    input  logic [N*FP8_W-1:0] b_vec,
    output logic [N*FP8_W-1:0] a_west,
    output logic [N*FP8_W-1:0] b_north,
    output logic               pe_clear,
    output logic               busy,
    output logic               done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int c_DRAIN_W = $clog2(2 * N + 1);
    // Straight from CLEAR nothing was injected, so the drain is the bare grid
    // crossing time. After a beat, the final beat's own injection cycle is
    // added on top so that done lands after PE(N-1,N-1) accumulates it.
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_FROM_CLEAR = c_DRAIN_W'(drain_cycles(N) - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_FROM_BEAT  = c_DRAIN_W'(drain_cycles(N));

    feeder_state_t          r_state;
    feeder_state_t          w_state_nxt;
    logic [KW-1:0]          r_k_rem;
    logic [KW-1:0]          w_k_rem_nxt;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [c_DRAIN_W-1:0]   w_drain_cnt_nxt;
    logic                   r_in_ready;
    logic                   r_pe_clear;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;
    logic [N*FP8_W-1:0]     w_a_inj;
    logic [N*FP8_W-1:0]     w_b_inj;

    assign w_accept = r_in_ready & in_valid;

    // Next-state, tile-depth and drain-counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_rem_nxt     = r_k_rem;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_k_rem_nxt = k_len;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (r_k_rem != '0) begin
                    w_state_nxt = STREAM;
                end else begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_FROM_CLEAR;
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_k_rem_nxt = r_k_rem - KW'(1);
                    if (r_k_rem == KW'(1)) begin
                        w_state_nxt     = DRAIN;
                        w_drain_cnt_nxt = c_DRAIN_FROM_BEAT;
                    end
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - c_DRAIN_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; control outputs are registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k_rem     <= '0;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b0;
            r_pe_clear  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k_rem     <= w_k_rem_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_in_ready  <= (w_state_nxt == STREAM);
            r_pe_clear  <= (w_state_nxt == CLEAR);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign in_ready = r_in_ready;
    assign pe_clear = r_pe_clear;
    assign busy     = r_busy;
    assign done     = r_done;

    // Anything other than an accepted beat enters the lanes as a zero bubble.
    assign w_a_inj = w_accept ? a_vec : {N{FP8_ZERO}};
    assign w_b_inj = w_accept ? b_vec : {N{FP8_ZERO}};

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (FP8_W)
        ) u_a_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (w_a_inj[i*FP8_W +: FP8_W]),
            .o_data (a_west[i*FP8_W +: FP8_W])
        );

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (FP8_W)
        ) u_b_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_data (w_b_inj[i*FP8_W +: FP8_W]),
            .o_data (b_north[i*FP8_W +: FP8_W])
        );
    end : g_lane

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count STREAM cycles starved of input; cleared at each tile's CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STREAM) && !in_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : systolic_skew_feeder
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Self-checking bench for systolic_skew_feeder (N=4). A table
//                of tile records drives the handshake; every accepted beat is
//                pushed to a scoreboard and popped when lane 0 must show it,
//                while a per-edge injection history predicts the skewed
//                lanes. Timing terms: "edge e" is the e-th rising clock edge;
//                outputs are read between edges after the registers updated.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int N    = 4;
    localparam int KW   = 8;
    localparam int HMAX = 4096;

    logic            clk = 1'b1;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*8-1:0]  a_vec = '0;
    logic [N*8-1:0]  b_vec = '0;
    logic [N*8-1:0]  a_west;
    logic [N*8-1:0]  b_north;
    logic            pe_clear;
    logic            busy;
    logic            done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    systolic_skew_feeder #(.N(N), .KW(KW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .a_west   (a_west),
        .b_north  (b_north),
        .pe_clear (pe_clear),
        .busy     (busy),
        .done     (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    typedef struct {
        int          k;
        logic [31:0] pat;
        logic        fixed;
        logic [31:0] fa;
        logic [31:0] fb;
        int          mode;   // 0 plain, 1 stray starts, 2 reset in drain
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt;
    int          first_acc;
    int          last_acc;
    int          done_seen = 0;
    logic [31:0] ha [HMAX];
    logic [31:0] hb [HMAX];
    beat_t       sb [$];
    vec_t        tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare outputs for the current edge, then record what the next edge injects.
    task automatic monitor();
        beat_t bt;
        int    e;
        if (cyc + 1 >= HMAX) begin
            $display("FAIL history_overflow: got %0d expected <%0d", cyc, HMAX);
            $fatal(1, "history overflow");
        end
        if (!rst_n) begin
            chk("rst_a_west", a_west, '0);
            chk("rst_b_north", b_north, '0);
            chk("rst_ctrl", {busy, in_ready, pe_clear, done}, 4'b0000);
            for (int x = cyc - N - 1; x <= cyc + 1; x++) begin
                if (x >= 0) begin
                    ha[x] = '0;
                    hb[x] = '0;
                end
            end
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].at == cyc) begin
                bt = sb.pop_front();
                chk("lane0_beat", {a_west[7:0], b_north[7:0]}, {bt.a[7:0], bt.b[7:0]});
            end else begin
                chk("lane0_zero", {a_west[7:0], b_north[7:0]}, 16'h0000);
            end
            for (int i = 1; i < N; i++) begin
                e = cyc - i;
                chk($sformatf("lane%0d_skew", i), {a_west[8*i +: 8], b_north[8*i +: 8]},
                    (e >= 0) ? {ha[e][8*i +: 8], hb[e][8*i +: 8]} : 16'h0000);
            end
            if (done) done_seen++;
            if (in_valid && in_ready) begin
                ha[cyc+1] = a_vec;
                hb[cyc+1] = b_vec;
                bt.at = cyc + 1;
                bt.a  = a_vec;
                bt.b  = b_vec;
                sb.push_back(bt);
                acc_cnt++;
                last_acc = cyc + 1;
                if (first_acc < 0) first_acc = cyc + 1;
            end else begin
                ha[cyc+1] = '0;
                hb[cyc+1] = '0;
            end
        end
    endtask

    // One clock: monitor between edges, then return just after the next edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_tile(input vec_t v);
        int s, p, zeros, guard, done_edge, exp_done, nd;
        acc_cnt   = 0;
        first_acc = -1;
        last_acc  = -1;
        nd        = done_seen;

        start    = 1'b1;
        k_len    = v.k[KW-1:0];
        in_valid = 1'b0;
        tick();
        s = cyc;
        start    = 1'b0;
        in_valid = 1'b1;               // ignored during CLEAR
        chk("pe_clear_on", pe_clear, 1'b1);
        chk("busy_on", busy, 1'b1);
        chk("in_ready_clear", in_ready, 1'b0);
        tick();
        chk("pe_clear_off", pe_clear, 1'b0);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cleared", stall_cnt, 16'd0);
`endif
        in_valid = 1'b0;

        p = 0;
        zeros = 0;
        guard = 0;
        while (acc_cnt < v.k && guard < 64) begin
            chk("in_ready_stream", in_ready, 1'b1);
            in_valid = (p < 32) ? v.pat[p] : 1'b1;
            if (!in_valid) zeros++;
            a_vec = v.fixed ? v.fa : $urandom();
            b_vec = v.fixed ? v.fb : $urandom();
            start = (v.mode == 1 && p == 1);
            if (start) k_len = 8'hAA;
            p++;
            guard++;
            tick();
        end
        if (guard >= 64) chk("stream_timeout", acc_cnt, v.k);
        in_valid = 1'b0;
        start    = 1'b0;
        if (v.k > 0) begin
            chk("in_ready_drop", in_ready, 1'b0);
            if (v.pat[0]) chk("first_accept_edge", first_acc, s + 2);
        end

        done_edge = -1;
        guard = 0;
        while (guard < 40) begin
            if (v.mode == 2 && guard == 2) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_lanes", {a_west, b_north}, '0);
                chk("async_rst_ctrl", {busy, in_ready, pe_clear, done}, 4'b0000);
                tick();
                tick();
                rst_n = 1'b1;
                repeat (20) tick();
                chk("no_done_after_reset", done_seen, nd);
                return;
            end
            start = (v.mode == 1 && guard == 2);
            if (start) k_len = 8'h55;
            tick();
            start = 1'b0;
            guard++;
            chk("in_ready_drain", in_ready, 1'b0);
            if (done) begin
                done_edge = cyc;
                break;
            end
        end
        exp_done = ((v.k > 0) ? last_acc : s) + 2 * N;
        chk("done_edge", done_edge, exp_done);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_at_done", stall_cnt, zeros);
`endif
        tick();
        chk("done_width", done, 1'b0);
        chk("busy_fall", busy, 1'b0);
        repeat (12) tick();
        chk("accept_count", acc_cnt, v.k);
        chk("single_done", done_seen, nd + 1);
    endtask

    initial begin
        for (int i = 0; i < HMAX; i++) begin
            ha[i] = '0;
            hb[i] = '0;
        end
        tbl[0] = '{1, 32'hFFFF_FFFF, 1'b1, 32'h3838_3838, 32'h4040_4040, 0};
        tbl[1] = '{3, 32'h0000_0015, 1'b0, 32'h0, 32'h0, 0};
        tbl[2] = '{0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 0};
        tbl[3] = '{4, 32'hFFFF_FFFF, 1'b1, 32'h8000_8080, 32'h7F80_FF01, 0};
        tbl[4] = '{2, 32'h0000_0044, 1'b0, 32'h0, 32'h0, 0};
        tbl[5] = '{3, 32'h0000_0007, 1'b0, 32'h0, 32'h0, 1};
        tbl[6] = '{3, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 2};
        tbl[7] = '{5, 32'h0000_002D, 1'b0, 32'h0, 32'h0, 0};

        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {a_west, b_north, busy, in_ready, pe_clear, done}, '0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int t = 0; t < 8; t++) begin
            run_tile(tbl[t]);
        end

        chk("total_done_pulses", done_seen, 7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_systolic_skew_feeder
`default_nettype wire

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream operand stage for the N×N FP8 E4M3 processing-element grid. It accepts one K-step operand beat per handshake: column k of A and row k of B, each N FP8 lanes. It skews lane i by i cycles onto the west (A) and north (B) edges of the grid. It also sequences the PE clear pulse, zero-fills bubbles and the drain, and reports completion once every PE accumulator holds its final tile result.

Parameters:
N, 4, grid dimension (lanes per operand edge), 1..16
KW, 8, width of the k_len field; max tile depth 2^KW-1

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a tile; sampled only in IDLE
k_len  in  KW  beats in the tile; captured with start
in_valid  in  1  operand beat valid
in_ready  out  1  feeder accepts a beat this cycle
a_vec  in  N*8  A column k; lane i = bits [8i+7:8i], FP8 E4M3
b_vec  in  N*8  B row k; lane j = bits [8j+7:8j], FP8 E4M3
a_west  out  N*8  to a_in of PE(i,0), lane i
b_north  out  N*8  to b_in of PE(0,j), lane j
pe_clear  out  1  to clear of every PE
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse: all PE results final

Behaviour:
- Reset (async assert, sync release): state=IDLE; all skew registers, a_west, b_north, pe_clear, done and busy are 0; in_ready is 0.
- The FSM has five states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE, start=1: capture k_len into k_rem and go to CLEAR. A start seen in any other state is ignored.
- CLEAR: lasts one cycle. Registered pe_clear=1 in that same cycle. Lanes inject 0x00. Next state is STREAM if k_rem≠0, else DRAIN.
- STREAM: in_ready=1. A beat is accepted when in_valid&&in_ready.
  - Accept: the lane inputs take a_vec/b_vec and k_rem decrements.
  - No beat: the lane inputs take 0x00 (a bubble; the product is 0, so the accumulators are unaffected).
  - The beat that brings k_rem to 0 moves the FSM to DRAIN. in_ready drops in the following cycle.
- DRAIN: in_ready=0, lanes inject 0x00, and a counter runs 2N-1 cycles. After that the FSM goes to DONE.
- DONE: lasts one cycle. done=1, then the FSM returns to IDLE. The PE results stay stable while zeros keep flowing; they are held until the next pe_clear.
- Skew timing: a lane-i value injected at edge t appears on a_west/b_north lane i at edge t+1+i. Lane 0 has one register stage and lane i has i+1 stages. All outputs are registered.
- pe_clear occupies the cycle before lane 0 shows the first beat. Every PE therefore sees clear before its first operand.
- Latency: the first beat is accepted at edge t0 and the last at edge tL. done is asserted at edge tL+2N+1, which is after PE(N-1,N-1) has registered its final accumulate.
- FP8 handling: lanes pass opaque bytes, with no decode. -0 (0x80) is forwarded unchanged.
- rst_n asserted mid-tile: everything returns to the reset state at once and no done is produced. The grid must be cleared by the next tile's CLEAR.
- in_valid is ignored outside STREAM. a_vec/b_vec are don't-care when not accepted.

Optional Feature:
FEEDER_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. It counts STREAM cycles with in_valid=0, saturating at 0xFFFF. It is zeroed in CLEAR and by reset, and holds its value in other states.
- Undefined: the port and the counter are absent, and timing is identical.

Decomposition:
- Shared package tpu_pkg:
  - FP8_W=8 and FP8_ZERO=8'h00.
  - The feeder_state_t enum {IDLE,CLEAR,STREAM,DRAIN,DONE}.
  - A function drain_cycles(N)=2N-1.
- One sub-module, skew_delay_line (parameters DEPTH, W): a DEPTH-stage shift register with async active-low reset. It is instantiated 2N times with DEPTH=i+1.
- The FSM, counters and handshake stay in systolic_skew_feeder.

Test Plan:
- N=4, start with k_len=1; beat a_vec=0x38383838 (1.0), b_vec=0x40404040 (2.0) accepted at edge t.
  - pe_clear is at t-1, and a_west lane 0 = 0x38 at t+1.
  - a_west lane 3 = 0x38 at t+4, and is 0x00 at every other cycle.
  - done at t+9, busy falls at t+10.
- N=4, k_len=3 with in_valid toggling 1,0,1,0,1.
  - Exactly 3 beats are accepted and zeros fill the gaps.
  - Lane i output equals lane 0's sequence delayed by i.
  - done occurs 9 cycles after the third accept.
- k_len=0: the sequence is CLEAR → DRAIN(7) → DONE. No in_ready ever, all lane outputs stay 0, and done=1 for 1 cycle.
- A start asserted during STREAM and during DRAIN is ignored: k_rem and the state are unaffected, and only one done is produced.
- rst_n pulled low two cycles into DRAIN: all outputs are 0 asynchronously, the state is IDLE, and no done is seen. A fresh start then runs normally.
- With FEEDER_STALL_CNT_EN, k_len=2 and 5 idle STREAM cycles: stall_cnt=5 at DONE, and it reads 0 after the next CLEAR.
